// File: rtl/alu_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_writeback_unit
// Purpose  : Execute/write-back stage wrapped around an 8-entry register
//            file. Accepts one command at a time, drives the file's two read
//            addresses, latches the returned operands, computes the result
//            (single-cycle ALU op or multi-cycle shift-add multiply) and
//            drives the file's write port for exactly one cycle.
// Ports    : clk             - system clock, rising edge
//            reset           - asynchronous, active-low
//            start           - command strobe, sampled only in IDLE
//            op/rs1/rs2/rd   - command fields
//            Read_Data_1/2   - operands returned by the register file
//            Read_Register_1/2, reg_Write, Write_Register, Write_Data
//                            - register file read-address and write port
//            busy/done       - status (busy = not IDLE, done = WB pulse)
//            zero/carry      - result flags, registered with the result
// Revision : 1.0 - initial release
// ============================================================================
module alu_writeback_unit #(
  parameter int WORD_LENGTH    = 8,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                op,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [WORD_LENGTH-1:0]    Read_Data_1,
  input  logic [WORD_LENGTH-1:0]    Read_Data_2,
  output logic [REG_ADDR_WIDTH-1:0] Read_Register_1,
  output logic [REG_ADDR_WIDTH-1:0] Read_Register_2,
  output logic                      reg_Write,
  output logic [REG_ADDR_WIDTH-1:0] Write_Register,
  output logic [WORD_LENGTH-1:0]    Write_Data,
  output logic                      busy,
  output logic                      done,
  output logic                      zero,
  output logic                      carry
);

  localparam int CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured command
  logic [2:0]                op_q;
  logic [REG_ADDR_WIDTH-1:0] rr1_q, rr2_q, wr_q;

  // Latched operands
  logic [WORD_LENGTH-1:0]    a_q, b_q;

  // Result and flags
  logic [WORD_LENGTH-1:0]    res_q;
  logic                      zero_q, carry_q;

  // Shift-add multiplier state
  logic [2*WORD_LENGTH-1:0]  acc_q, mcand_q;
  logic [WORD_LENGTH-1:0]    mplier_q;
  logic [CNT_W-1:0]          cnt_q;

  // Combinational ALU outputs
  logic [WORD_LENGTH-1:0]    w_alu_res;
  logic                      w_alu_carry;
  logic [WORD_LENGTH:0]      w_sum;
  logic [2*WORD_LENGTH-1:0]  w_acc_next;
  logic                      w_mul_last;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        // MUL stays here until its final iteration; everything else is one cycle
        if (op_q != OP_MUL || w_mul_last) state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-cycle ALU
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_sum       = '0;
    case (op_q)
      OP_ADD: begin
        w_sum       = {1'b0, a_q} + {1'b0, b_q};
        w_alu_res   = w_sum[WORD_LENGTH-1:0];
        w_alu_carry = w_sum[WORD_LENGTH];
      end
      OP_SUB: begin
        // Two's-complement subtract: carry out set means no borrow
        w_sum       = {1'b0, a_q} + {1'b0, ~b_q} + {{WORD_LENGTH{1'b0}}, 1'b1};
        w_alu_res   = w_sum[WORD_LENGTH-1:0];
        w_alu_carry = w_sum[WORD_LENGTH];
      end
      OP_AND: w_alu_res = a_q & b_q;
      OP_OR:  w_alu_res = a_q | b_q;
      OP_XOR: w_alu_res = a_q ^ b_q;
      OP_SHL: w_alu_res = a_q << b_q[2:0];
      // The immediate travels in the captured read addresses
      OP_LDI: w_alu_res = WORD_LENGTH'({rr1_q, rr2_q});
      default: w_alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift-add multiply step
  // --------------------------------------------------------------------------
  assign w_acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign w_mul_last = (cnt_q == CNT_W'(WORD_LENGTH - 1));

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      rr1_q    <= '0;
      rr2_q    <= '0;
      wr_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            rr1_q <= rs1;
            rr2_q <= rs2;
            wr_q  <= rd;
          end
        end
        S_READ: begin
          a_q      <= Read_Data_1;
          b_q      <= Read_Data_2;
          acc_q    <= '0;
          mcand_q  <= {{WORD_LENGTH{1'b0}}, Read_Data_1};
          mplier_q <= Read_Data_2;
          cnt_q    <= '0;
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q    <= w_acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            // Result registers only move on the final step so they keep
            // the previous command's value until this one is complete
            if (w_mul_last) begin
              res_q   <= w_acc_next[WORD_LENGTH-1:0];
              carry_q <= |w_acc_next[2*WORD_LENGTH-1:WORD_LENGTH];
              zero_q  <= (w_acc_next[WORD_LENGTH-1:0] == '0);
            end
          end else begin
            res_q   <= w_alu_res;
            carry_q <= w_alu_carry;
            zero_q  <= (w_alu_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Read_Register_1 = rr1_q;
  assign Read_Register_2 = rr2_q;
  assign Write_Register  = wr_q;
  assign Write_Data      = res_q;
  assign zero            = zero_q;
  assign carry           = carry_q;
  assign busy            = (state_q != S_IDLE);
  assign reg_Write       = (state_q == S_WB);
  assign done            = (state_q == S_WB);

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_writeback_unit
// Purpose  : Self-checking bench for alu_writeback_unit. Wraps the DUT around
//            a behavioural 8-entry register file, keeps a reference model of
//            the register contents and a queue of expected write-backs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_writeback_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op, rs1, rs2, rd;
  logic [7:0] Read_Data_1, Read_Data_2;
  logic [2:0] Read_Register_1, Read_Register_2, Write_Register;
  logic       reg_Write, busy, done, zero, carry;
  logic [7:0] Write_Data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
    logic       z;
    logic       c;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] rf [8];
  logic [7:0] m  [8];

  always #5 clk = ~clk;

  alu_writeback_unit #(.WORD_LENGTH(8), .REG_ADDR_WIDTH(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .op              (op),
    .rs1             (rs1),
    .rs2             (rs2),
    .rd              (rd),
    .Read_Data_1     (Read_Data_1),
    .Read_Data_2     (Read_Data_2),
    .Read_Register_1 (Read_Register_1),
    .Read_Register_2 (Read_Register_2),
    .reg_Write       (reg_Write),
    .Write_Register  (Write_Register),
    .Write_Data      (Write_Data),
    .busy            (busy),
    .done            (done),
    .zero            (zero),
    .carry           (carry)
  );

  // Behavioural register file: combinational read, write on rising edge
  assign Read_Data_1 = rf[Read_Register_1];
  assign Read_Data_2 = rf[Read_Register_2];
  always @(posedge clk) begin
    if (reg_Write) rf[Write_Register] <= Write_Data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {carry, res}
  function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] a,
                                       input logic [7:0] b, input logic [2:0] s1,
                                       input logic [2:0] s2);
    int         t;
    logic [7:0] sh;
    case (o)
      3'd0: begin t = int'(a) + int'(b); return {1'(t > 255), 8'(t)}; end
      3'd1: return {1'(a >= b), 8'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: begin sh = a << b[2:0]; return {1'b0, sh}; end
      3'd6: begin t = int'(a) * int'(b); return {1'(t > 255), 8'(t)}; end
      default: return {1'b0, 2'b00, s1, s2};
    endcase
  endfunction

  // Issue one command, wait for its write-back and score it.
  // poke > 0 drives a second start so that it is sampled at edge N+poke.
  task automatic run_cmd(input logic [2:0] o, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] d, input int exp_lat, input int poke,
                         output logic [7:0] wdata);
    logic [8:0] r;
    exp_t       e;
    int         cycles;
    r = model(o, m[s1], m[s2], s1, s2);
    sbq.push_back('{rd: d, data: r[7:0], z: (r[7:0] == 8'd0), c: r[8]});
    start = 1'b1; op = o; rs1 = s1; rs2 = s2; rd = d;
    #1;
    chk("busy_before_edge", 32'(busy), 0);
    tick();
    start = 1'b0;
    op = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom);
    chk("busy_after_accept", 32'(busy), 1);
    chk("read_reg1", 32'(Read_Register_1), 32'(s1));
    chk("read_reg2", 32'(Read_Register_2), 32'(s2));
    cycles = 0;
    while (reg_Write !== 1'b1 && cycles < 20) begin
      if (poke > 0 && cycles == poke - 1) begin
        start = 1'b1; rs1 = ~s1; op = 3'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
      if (poke > 0 && cycles == poke) begin
        chk("busy_ignored_start", 32'(busy), 1);
        chk("read_reg1_held", 32'(Read_Register_1), 32'(s1));
      end
    end
    start = 1'b0;
    chk("writeback_latency", cycles, exp_lat);
    e = sbq.pop_front();
    wdata = Write_Data;
    chk("done_pulse", 32'(done), 1);
    chk("write_register", 32'(Write_Register), 32'(e.rd));
    chk("write_data", 32'(Write_Data), 32'(e.data));
    chk("zero_flag", 32'(zero), 32'(e.z));
    chk("carry_flag", 32'(carry), 32'(e.c));
    tick();
    chk("reg_write_one_cycle", 32'(reg_Write), 0);
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_commit", 32'(busy), 0);
    chk("regfile_commit", 32'(rf[e.rd]), 32'(e.data));
    m[e.rd] = e.data;
  endtask

  initial begin
    logic [7:0] wd;
    logic [7:0] rb_tbl [6];
    int         wr_cnt;
    rb_tbl[0] = 8'h05; rb_tbl[1] = 8'h3F; rb_tbl[2] = 8'h44;
    rb_tbl[3] = 8'hC6; rb_tbl[4] = 8'h3B; rb_tbl[5] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'h00;
      m[i]  = 8'h00;
    end

    // Reset held with random inputs
    reset = 1'b0; start = 1'b0; op = 3'd0; rs1 = 3'd0; rs2 = 3'd0; rd = 3'd0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); op = 3'($urandom); rs1 = 3'($urandom);
      rs2 = 3'($urandom); rd = 3'($urandom);
      tick();
      chk("reset_outputs", 32'({Read_Register_1, Read_Register_2, reg_Write, Write_Register,
                                Write_Data, busy, done, zero, carry}), 0);
    end
    start = 1'b0;
    reset = 1'b1;

    // LDI
    run_cmd(3'd7, 3'd0, 3'd5, 3'd2, 2, 0, wd);
    run_cmd(3'd7, 3'd7, 3'd7, 3'd3, 2, 0, wd);
    // ADD / SUB
    run_cmd(3'd0, 3'd2, 3'd3, 3'd4, 2, 0, wd);
    run_cmd(3'd1, 3'd2, 3'd3, 3'd5, 2, 0, wd);
    run_cmd(3'd1, 3'd2, 3'd2, 3'd7, 2, 0, wd);
    // MUL with an ignored start at N+4
    run_cmd(3'd6, 3'd3, 3'd2, 3'd6, 9, 4, wd);
    // Remaining ops into scratch registers r0/r1
    run_cmd(3'd2, 3'd3, 3'd4, 3'd0, 2, 0, wd);
    run_cmd(3'd3, 3'd2, 3'd5, 3'd1, 2, 0, wd);
    run_cmd(3'd4, 3'd3, 3'd3, 3'd0, 2, 0, wd);
    run_cmd(3'd5, 3'd2, 3'd3, 3'd1, 2, 0, wd);
    run_cmd(3'd0, 3'd5, 3'd5, 3'd0, 2, 0, wd);
    run_cmd(3'd6, 3'd2, 3'd2, 3'd1, 9, 0, wd);

    // Reset mid-MUL: aimed at r7 so a leaked write shows in the readback
    start = 1'b1; op = 3'd6; rs1 = 3'd3; rs2 = 3'd3; rd = 3'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_outputs", 32'({Read_Register_1, Read_Register_2, reg_Write, Write_Register,
                              Write_Data, busy, done, zero, carry}), 0);
    wr_cnt = 0;
    repeat (2) begin
      tick();
      if (reg_Write === 1'b1) wr_cnt++;
    end
    reset = 1'b1;
    repeat (12) begin
      tick();
      if (reg_Write === 1'b1) wr_cnt++;
    end
    chk("abort_no_write", wr_cnt, 0);

    // Normal LDI after abort
    run_cmd(3'd7, 3'd2, 3'd1, 3'd1, 2, 0, wd);
    chk("ldi_after_abort", 32'(wd), 32'h11);

    // Readback r2..r7 through the DUT read path (OR rk,rk)
    for (int k = 2; k < 8; k++) begin
      run_cmd(3'd3, 3'(k), 3'(k), 3'd0, 2, 0, wd);
      chk("readback", 32'(wd), 32'(rb_tbl[k-2]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_writeback_unit.md
# alu_writeback_unit

Sequencer-driven execute/write-back stage wrapped around the 8-entry register file. Accepts one operation command at a time and drives the register file's two read addresses. It captures the returned operands, computes the result (single-cycle logic/arithmetic or a multi-cycle shift-add multiply), then drives the register file's write port for exactly one cycle. Sits directly upstream and downstream of the register file: its read-address outputs and write port connect to the file, and the file's read-data outputs return to it.

## Interface
- WORD_LENGTH, 8, data width; matches the register file word.
- REG_ADDR_WIDTH, 3, register address width (8 registers).

- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 LDI.
- rs1  in  REG_ADDR_WIDTH  source A address (LDI: immediate high bits).
- rs2  in  REG_ADDR_WIDTH  source B address (LDI: immediate low bits).
- rd  in  REG_ADDR_WIDTH  destination address.
- Read_Data_1  in  WORD_LENGTH  operand A from register file (combinational read).
- Read_Data_2  in  WORD_LENGTH  operand B from register file.
- Read_Register_1  out  REG_ADDR_WIDTH  captured rs1 to register file.
- Read_Register_2  out  REG_ADDR_WIDTH  captured rs2 to register file.
- reg_Write  out  1  write enable to register file.
- Write_Register  out  REG_ADDR_WIDTH  captured rd.
- Write_Data  out  WORD_LENGTH  result.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- zero  out  1  result == 0, registered with result.
- carry  out  1  carry/no-borrow/overflow flag, registered with result.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: start=1 captures op, rs1, rs2 and rd, then moves to READ. Read_Register_1/2 update to rs1/rs2 on this edge.
- READ: operands A=Read_Data_1 and B=Read_Data_2 are latched at the end of the cycle, then the FSM moves to EXEC.
- EXEC, non-MUL ops: result is computed and registered in one cycle, then the FSM moves to WB.
- EXEC, MUL: WORD_LENGTH-iteration shift-add with a 2*WORD_LENGTH-bit accumulator and an internal iteration counter. The FSM moves to WB after the final iteration.
- WB: reg_Write=1 and done=1 for exactly one cycle, then the FSM returns to IDLE.
- Arithmetic rules:
  - ADD: {carry,res} = A+B, with WORD_LENGTH+1 bits.
  - SUB: {carry,res} = A+~B+1; carry=1 means no borrow.
  - AND/OR/XOR: carry=0.
  - SHL: res = A << B[2:0]; carry=0.
  - MUL: res is the low WORD_LENGTH bits of A*B; carry=1 if the high half is nonzero.
  - LDI: res is the zero-extended {rs1,rs2} (6-bit immediate); Read_Data is ignored; carry=0.
- zero = (res == 0) for all ops.
- Any rd, including 0, is written; protecting any register is the file's concern.
- start while busy=1 is ignored; the command is not queued.
- Reset value of every output and internal register is 0; the FSM resets to IDLE.
- Reset asserted mid-operation aborts immediately: no reg_Write is issued and the partial MUL is discarded.
- Read_Register_1/2, Write_Register, Write_Data, zero and carry hold their values until the next accepted command.

## Timing
- start sampled high at edge N.
- Non-MUL: READ in cycle N→N+1, EXEC in N+1→N+2, WB (reg_Write, done) in N+2→N+3. The register file commits at edge N+3.
- MUL: EXEC occupies WORD_LENGTH cycles. WB occurs in cycle N+1+WORD_LENGTH→N+2+WORD_LENGTH, and the commit is at edge N+2+WORD_LENGTH (N+10 for the default width).
- busy rises after edge N and falls after the commit edge.
- The earliest next start is sampled at the commit edge + 1 cycle.
- Back-to-back dependent ops are safe: a following op reads in READ, which is after the prior commit.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0, busy=0. Release reset and strobe start with no clk edge pending → nothing is accepted until the next rising edge.
- LDI: op=111, rs1=0, rs2=5, rd=2 → reg_Write high during cycle N+2 only, Write_Register=2, Write_Data=0x05, done pulse. Then rs1=7, rs2=7, rd=3 → Write_Data=0x3F, zero=0.
- ADD/SUB: ADD with rd=4, rs1=2, rs2=3 → 0x44, carry=0. SUB with rd=5, rs1=2, rs2=3 → 0xC6, carry=0 (borrow). SUB with rd=7, rs1=2, rs2=2 → 0x00, zero=1, carry=1.
- MUL: rd=6, rs1=3, rs2=2 → 63*5=315 gives Write_Data=0x3B, carry=1, reg_Write only at cycle N+9. A second start pulsed at N+4 is ignored (no extra write, busy stays high).
- Reset mid-MUL: assert reset at N+5 → reg_Write never rises, busy=0 immediately. After release, an LDI completes normally with the 3-cycle latency.
- Register-file readback: after the scenarios above, read r2…r7 via Read_Register → 0x05, 0x3F, 0x44, 0xC6, 0x3B, 0x00.
